elastic_fork_n: RTL

- Parametrised N-way elastic fork for the PE interconnect. It copies one upstream valid/stop token to OUT_NUM downstream branches.
- Each branch can be enabled at runtime by the mapper's connection configuration.
- EAGER mode tracks per-branch delivery: a branch that has taken the token is not re-presented while slower branches stall. LAZY mode releases all branches in the same cycle.
- Includes a delivered-token counter for simulator profiling.

---
 rtl/elastic_fork_n.sv | 104 ++++++++++
 1 files changed

// File: rtl/elastic_fork_n.sv
// elastic_fork_n
//
// N-way elastic fork for the PE interconnect. One upstream valid/stop token
// is copied to OUT_NUM downstream branches.
//
// Handshake (valid/stop): a token moves across an interface in any cycle
// where valid=1 and stop=0. Upstream keeps in_data stable while
// in_valid & in_stop. A downstream branch may raise out_stop at any time.
// valid never waits on stop from the same interface.
//
// EAGER=1: each branch takes the token as soon as it is ready. done_q records
//          the branches that already have it, so they are not shown the same
//          token again. The token completes when no pending branch stalls.
// EAGER=0: all enabled branches take the token together in one cycle. The
//          handshake is purely combinational and done_q stays zero.
//
// Ports:
//   clk, reset_n  clock; asynchronous active-low reset
//   in_data       upstream payload
//   in_valid      upstream token present
//   in_stop       backpressure to upstream. This is a combinational function
//                 of out_stop and out_enable.
//   out_data      per-branch payload; slice i is a copy of in_data
//   out_valid     per-branch valid
//   out_stop      per-branch backpressure
//   out_enable    branch connection mask from the mapper
//   token_count   completed tokens (wraps); used for profiling
module elastic_fork_n #(
  parameter int DATA_WIDTH  = 32,
  parameter int OUT_NUM     = 4,
  parameter int EAGER       = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_stop,
  output logic [OUT_NUM*DATA_WIDTH-1:0] out_data,
  output logic [OUT_NUM-1:0]            out_valid,
  input  logic [OUT_NUM-1:0]            out_stop,
  input  logic [OUT_NUM-1:0]            out_enable,
  output logic [COUNT_WIDTH-1:0]        token_count
);

  logic [OUT_NUM-1:0]     done_q, done_d;
  logic [OUT_NUM-1:0]     pending;
  logic [OUT_NUM-1:0]     stalled;
  logic [OUT_NUM-1:0]     others;
  logic [OUT_NUM-1:0]     accept;
  logic                   complete;
  logic [COUNT_WIDTH-1:0] token_count_q, token_count_d;

  assign out_data    = {OUT_NUM{in_data}};
  assign token_count = token_count_q;

  always_comb begin
    others        = '0;
    out_valid     = '0;
    done_d        = '0;
    token_count_d = token_count_q;

    // In lazy mode done_q is always zero, so pending equals out_enable.
    pending = out_enable & ~done_q;
    stalled = pending & out_stop;
    in_stop = in_valid & (|stalled);

    if (EAGER != 0) begin
      // valid comes from done state only, so there is no out_stop->out_valid path.
      out_valid = {OUT_NUM{in_valid}} & pending;
    end else begin
      // A branch is shown the token only when every other enabled branch
      // can take it too. This lets all of them transfer in the same cycle.
      for (int i = 0; i < OUT_NUM; i++) begin
        others        = stalled;
        others[i]     = 1'b0;
        out_valid[i]  = in_valid & pending[i] & ~(|others);
      end
    end

    accept   = out_valid & ~out_stop;
    complete = in_valid & ~in_stop;

    // done clears on completion even for branches that are now disabled.
    if ((EAGER != 0) && !complete) begin
      done_d = done_q | accept;
    end

    if (complete) begin
      token_count_d = token_count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q        <= '0;
      token_count_q <= '0;
    end else begin
      done_q        <= done_d;
      token_count_q <= token_count_d;
    end
  end

endmodule
